// File: rtl/cla_word_sequencer.sv
// Multi-word add/subtract front end for a DWIDTH carry-lookahead slice, least-significant word first.
// One-cycle registered result; stalls input while a result is held unaccepted. Optional CLA_SEQ_OVF_EN adds out_ovf.

module cla_slice #(
  parameter int DWIDTH = 8
) (
  input  logic [DWIDTH-1:0] a,
  input  logic [DWIDTH-1:0] b,
  input  logic              cin,
  output logic [DWIDTH-1:0] sum,
  output logic              cout
);
  logic [DWIDTH-1:0] g;
  logic [DWIDTH-1:0] p;
  logic [DWIDTH:0]   c;
  logic              run;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is the flat OR of generate terms gated by the propagate chain above them.
  always_comb begin
    c    = '0;
    run  = 1'b0;
    c[0] = cin;
    for (int i = 0; i < DWIDTH; i++) begin
      c[i+1] = g[i];
      run    = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (run & g[j]);
        run    = run & p[j];
      end
      c[i+1] = c[i+1] | (run & cin);
    end
  end

  assign sum  = p ^ c[DWIDTH-1:0];
  assign cout = c[DWIDTH];
endmodule

module cla_word_sequencer #(
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] in_a,
  input  logic [DWIDTH-1:0] in_b,
  input  logic              in_sub,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_sum,
  output logic              out_last,
  output logic              out_cout
`ifdef CLA_SEQ_OVF_EN
  ,
  output logic              out_ovf
`endif
);
  typedef enum logic {FIRST, CONT} state_t;

  state_t            state_q, state_d;
  logic              carry_q, carry_d;
  logic              sub_q, sub_d;
  logic              valid_d, last_d, cout_d;
  logic [DWIDTH-1:0] sum_d;
  logic              accept, sub_eff, cin, cla_cout;
  logic [DWIDTH-1:0] b_eff, cla_sum;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  // The operation mode is latched on the first word; later words reuse it.
  assign sub_eff  = (state_q == FIRST) ? in_sub : sub_q;
  assign cin      = (state_q == FIRST) ? in_sub : carry_q;
  assign b_eff    = sub_eff ? ~in_b : in_b;

  cla_slice #(.DWIDTH(DWIDTH)) u_cla (
    .a    (in_a),
    .b    (b_eff),
    .cin  (cin),
    .sum  (cla_sum),
    .cout (cla_cout)
  );

  always_comb begin
    state_d = state_q;
    carry_d = carry_q;
    sub_d   = sub_q;
    valid_d = out_valid;
    sum_d   = out_sum;
    last_d  = out_last;
    cout_d  = out_cout;
    if (accept) begin
      if (state_q == FIRST) sub_d = in_sub;
      carry_d = cla_cout;
      sum_d   = cla_sum;
      cout_d  = cla_cout;
      last_d  = in_last;
      valid_d = 1'b1;
      state_d = in_last ? FIRST : CONT;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FIRST;
      carry_q   <= 1'b0;
      sub_q     <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_last  <= 1'b0;
      out_cout  <= 1'b0;
    end else begin
      state_q   <= state_d;
      carry_q   <= carry_d;
      sub_q     <= sub_d;
      out_valid <= valid_d;
      out_sum   <= sum_d;
      out_last  <= last_d;
      out_cout  <= cout_d;
    end
  end

`ifdef CLA_SEQ_OVF_EN
  logic ovf_d;

  // Signed overflow only has meaning at the operand's most-significant word.
  assign ovf_d = in_last && (in_a[DWIDTH-1] == b_eff[DWIDTH-1]) &&
                 (cla_sum[DWIDTH-1] != in_a[DWIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_ovf <= 1'b0;
    else if (accept) out_ovf <= ovf_d;
  end
`endif
endmodule
